// File: rtl/nota_generator.sv
// rtl/nota_generator.sv - fixed-pitch 50% duty square-wave tone generator
module nota_generator #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int NOTE_HZ = 440
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  localparam int HALF = (NOTE_HZ == 0) ? 0 : CLK_HZ / (2 * NOTE_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  // A zero or sub-cycle half period cannot be produced; refuse to build it.
  generate
    if (NOTE_HZ == 0 || HALF < 1) begin : g_cfg_err
      $error("nota_generator: invalid CLK_HZ/NOTE_HZ, half period below one cycle");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_out <= ~r_out;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_nota_generator.sv
// tb/tb_nota_generator.sv - directed checks of nota_generator at several pitches
module tb_nota_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_5, rst_1, rst_t;
  logic out_d, out_5, out_1, out_t;

  nota_generator #(.CLK_HZ(12_000_000), .NOTE_HZ(440)) u_def (.clk(clk), .rst(rst_d), .out(out_d));
  nota_generator #(.CLK_HZ(1000), .NOTE_HZ(100)) u_h5 (.clk(clk), .rst(rst_5), .out(out_5));
  nota_generator #(.CLK_HZ(2), .NOTE_HZ(1)) u_h1 (.clk(clk), .rst(rst_1), .out(out_1));
  nota_generator #(.CLK_HZ(1000), .NOTE_HZ(300)) u_tr (.clk(clk), .rst(rst_t), .out(out_t));

  typedef struct {
    logic rst;
    logic exp_out;
  } vec_t;

  vec_t vecs[26];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int hi;
    int lo;

    // HALF=5: reset hold, release, reset while high with cnt==3, restart
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b0};
    for (int i = 0; i < 8; i++) vecs[5 + i] = '{1'b0, (i >= 4) ? 1'b1 : 1'b0};
    vecs[13] = '{1'b1, 1'b0};
    for (int i = 0; i < 12; i++) vecs[14 + i] = '{1'b0, (i >= 4 && i <= 8) ? 1'b1 : 1'b0};

    rst_d = 1'b1;
    rst_5 = 1'b1;
    rst_1 = 1'b1;
    rst_t = 1'b1;

    for (int i = 0; i < 26; i++) begin
      rst_5 = vecs[i].rst;
      step();
      check($sformatf("h5_vec%0d", i), int'(out_5), int'(vecs[i].exp_out));
      if (i < 5) begin
        check($sformatf("def_reset%0d", i), int'(out_d), 0);
        check($sformatf("h1_reset%0d", i), int'(out_1), 0);
      end
    end

    // HALF=1: toggles every edge, first 1 on the first edge after release
    rst_1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("h1_toggle%0d", i), int'(out_1), (i % 2 == 0) ? 1 : 0);
    end

    // Truncated divider 1000/600 -> HALF=1, period of 2 cycles
    check("trunc_reset", int'(out_t), 0);
    rst_t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("trunc_toggle%0d", i), int'(out_t), (i % 2 == 0) ? 1 : 0);
    end

    // Default pitch: first rise, high time, low time, period
    check("def_reset_hold", int'(out_d), 0);
    rst_d = 1'b0;
    n = 0;
    while (n < 20000) begin
      step();
      n++;
      if (out_d) break;
    end
    check("def_first_rise_edge", n, 13636);
    hi = 0;
    while (hi < 20000) begin
      step();
      hi++;
      if (!out_d) break;
    end
    check("def_high_cycles", hi, 13636);
    lo = 0;
    while (lo < 20000) begin
      step();
      lo++;
      if (out_d) break;
    end
    check("def_low_cycles", lo, 13636);
    check("def_period", hi + lo, 27272);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
